// File: rtl/rast_perf_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rast_perf_monitor                                             |
// | Brief    : passive saturating cycle/triangle/sample/hit counters that    |
// |            observe the rasterizer sample-test and hit stages             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+

module rast_perf_monitor #(
  parameter int SIGFIG     = 24,
  parameter int RADIX      = 10,
  parameter int VERTS      = 3,
  parameter int AXIS       = 3,
  parameter int COLORS     = 3,
  parameter int PIPE_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [VERTS*AXIS*SIGFIG-1:0]  tri_R16S,
  input  logic [COLORS*SIGFIG-1:0]      color_R16U,
  input  logic                          validSamp_R16H,
  input  logic [2*SIGFIG-1:0]           sample_R16S,
  input  logic [AXIS*SIGFIG-1:0]        hit_R18S,
  input  logic [COLORS*SIGFIG-1:0]      color_R18U,
  input  logic                          hit_valid_R18H,
  output logic [CNT_W-1:0]              cycle_count,
  output logic [CNT_W-1:0]              triangle_count,
  output logic [CNT_W-1:0]              sample_count,
  output logic [CNT_W-1:0]              sample_hit_count
);

  localparam int               c_tri_w   = VERTS*AXIS*SIGFIG + COLORS*SIGFIG;
  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]   r_cycle_cnt;
  logic [CNT_W-1:0]   r_tri_cnt;
  logic [CNT_W-1:0]   r_samp_cnt;
  logic [CNT_W-1:0]   r_hit_cnt;
  logic [c_tri_w-1:0] r_last_tri;
  logic               r_have_tri;

  logic [c_tri_w-1:0] w_cur_tri;
  logic               w_samp_v;
  logic               w_hit_v;
  logic               w_new_tri;
  logic               w_unused;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == c_cnt_max) ? v : v + c_cnt_one;
  endfunction

  // Case equality keeps an X/Z valid from ever being counted in simulation.
  assign w_samp_v  = (validSamp_R16H === 1'b1);
  assign w_hit_v   = (hit_valid_R18H === 1'b1);
  assign w_cur_tri = {tri_R16S, color_R16U};
  assign w_new_tri = w_samp_v && (!r_have_tri || (w_cur_tri != r_last_tri));

  assign w_unused = ^{sample_R16S, hit_R18S, color_R18U, 32'(RADIX), 32'(PIPE_DEPTH)};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle_cnt <= '0;
      r_tri_cnt   <= '0;
      r_samp_cnt  <= '0;
      r_hit_cnt   <= '0;
      r_last_tri  <= '0;
      r_have_tri  <= 1'b0;
    end else begin
      r_cycle_cnt <= sat_inc(r_cycle_cnt);
      if (w_samp_v) begin
        r_samp_cnt <= sat_inc(r_samp_cnt);
        r_last_tri <= w_cur_tri;
        r_have_tri <= 1'b1;
      end
      if (w_new_tri) begin
        r_tri_cnt <= sat_inc(r_tri_cnt);
      end
      if (w_hit_v) begin
        r_hit_cnt <= sat_inc(r_hit_cnt);
      end
    end
  end

  assign cycle_count      = r_cycle_cnt;
  assign triangle_count   = r_tri_cnt;
  assign sample_count     = r_samp_cnt;
  assign sample_hit_count = r_hit_cnt;

endmodule

`default_nettype wire

// File: tb/tb_rast_perf_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_rast_perf_monitor                                          |
// | Brief    : self-checking bench for rast_perf_monitor (32-bit and 4-bit)  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+

module tb_rast_perf_monitor;

  localparam int c_tri_bits = 216;
  localparam int c_col_bits = 72;

  logic                  clk;
  logic                  rst;
  logic [c_tri_bits-1:0] tri_s;
  logic [c_col_bits-1:0] col_s;
  logic                  vs;
  logic [47:0]           samp_s;
  logic [71:0]           hitloc_s;
  logic [71:0]           hitcol_s;
  logic                  hv;
  logic [31:0]           cyc, tric, smpc, hitc;
  logic [3:0]            cyc4, tric4, smpc4, hitc4;

  rast_perf_monitor dut (
    .clk(clk), .rst(rst), .tri_R16S(tri_s), .color_R16U(col_s),
    .validSamp_R16H(vs), .sample_R16S(samp_s), .hit_R18S(hitloc_s),
    .color_R18U(hitcol_s), .hit_valid_R18H(hv),
    .cycle_count(cyc), .triangle_count(tric), .sample_count(smpc),
    .sample_hit_count(hitc)
  );

  rast_perf_monitor #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .tri_R16S(tri_s), .color_R16U(col_s),
    .validSamp_R16H(vs), .sample_R16S(samp_s), .hit_R18S(hitloc_s),
    .color_R18U(hitcol_s), .hit_valid_R18H(hv),
    .cycle_count(cyc4), .triangle_count(tric4), .sample_count(smpc4),
    .sample_hit_count(hitc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Pool entries: 0 = A, 1 = B, 2 = A with one colour bit flipped, 3 = C.
  logic [c_tri_bits-1:0] tri_pool [4];
  logic [c_col_bits-1:0] col_pool [4];

  // Reference: plain event counts, saturation applied only when compared.
  longint                           m_cyc, m_tri, m_smp, m_hit;
  logic [c_tri_bits+c_col_bits-1:0] m_last;
  bit                               m_have;

  typedef struct {
    bit  r;
    bit  v;
    bit  h;
    int  sel;
    int  n;
    int  ec;
    int  et;
    int  es;
    int  eh;
  } row_t;

  row_t tbl [16];

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sat4(input longint v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_tri = 0; m_smp = 0; m_hit = 0; m_last = '0; m_have = 0;
  endtask

  task automatic step(input bit r, input bit v, input bit h, input int sel);
    logic [c_tri_bits+c_col_bits-1:0] cur;
    rst      = r;
    vs       = v;
    hv       = h;
    tri_s    = tri_pool[sel];
    col_s    = col_pool[sel];
    samp_s   = 48'($urandom());
    hitloc_s = 72'($urandom());
    hitcol_s = 72'($urandom());
    cur      = {tri_pool[sel], col_pool[sel]};
    if (!r) begin
      model_reset();
    end else begin
      m_cyc++;
      if (h) m_hit++;
      if (v) begin
        m_smp++;
        if (!m_have || cur != m_last) m_tri++;
        m_last = cur;
        m_have = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".cycle"},    longint'(cyc),   m_cyc);
    chk({tag, ".tri"},      longint'(tric),  m_tri);
    chk({tag, ".samp"},     longint'(smpc),  m_smp);
    chk({tag, ".hit"},      longint'(hitc),  m_hit);
    chk({tag, ".cycle4"},   longint'(cyc4),  sat4(m_cyc));
    chk({tag, ".tri4"},     longint'(tric4), sat4(m_tri));
    chk({tag, ".samp4"},    longint'(smpc4), sat4(m_smp));
    chk({tag, ".hit4"},     longint'(hitc4), sat4(m_hit));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < c_tri_bits; b++) tri_pool[i][b] = 1'($urandom_range(0, 1));
      for (int b = 0; b < c_col_bits; b++) col_pool[i][b] = 1'($urandom_range(0, 1));
    end
    tri_pool[1][0] = ~tri_pool[0][0];
    tri_pool[3][1] = ~tri_pool[0][1];
    tri_pool[2]    = tri_pool[0];
    col_pool[2]    = col_pool[0] ^ 72'h1;

    //          r  v  h  sel n   cyc tri smp hit
    tbl[0]  = '{0, 1, 1, 1,  5,  0,  0,  0,  0};   // inputs ignored in reset
    tbl[1]  = '{1, 0, 0, 0, 10, 10,  0,  0,  0};
    tbl[2]  = '{1, 1, 0, 0,  6, 16,  1,  6,  0};   // one triangle, 6 samples
    tbl[3]  = '{0, 1, 1, 1,  1,  0,  0,  0,  0};
    tbl[4]  = '{1, 1, 0, 0,  3,  3,  1,  3,  0};   // A
    tbl[5]  = '{1, 1, 0, 1,  4,  7,  2,  7,  0};   // B
    tbl[6]  = '{1, 1, 0, 0,  2,  9,  3,  9,  0};   // A again
    tbl[7]  = '{0, 0, 0, 0,  1,  0,  0,  0,  0};
    tbl[8]  = '{1, 1, 0, 0,  2,  2,  1,  2,  0};
    tbl[9]  = '{1, 0, 0, 1,  5,  7,  1,  2,  0};   // gap, data wanders
    tbl[10] = '{1, 1, 0, 0,  2,  9,  1,  4,  0};   // A resumed
    tbl[11] = '{1, 1, 0, 2,  1, 10,  2,  5,  0};   // colour-only change
    tbl[12] = '{0, 0, 0, 0,  1,  0,  0,  0,  0};
    tbl[13] = '{1, 0, 1, 0,  4,  4,  0,  0,  4};   // hits alone
    tbl[14] = '{1, 1, 1, 0,  3,  7,  1,  3,  7};   // coincident
    tbl[15] = '{1, 1, 0, 0,  2,  9,  1,  5,  7};

    rst = 1'b0; vs = 1'b0; hv = 1'b0;
    tri_s = '0; col_s = '0; samp_s = '0; hitloc_s = '0; hitcol_s = '0;
    model_reset();
    @(negedge clk);

    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < tbl[r].n; k++) step(tbl[r].r, tbl[r].v, tbl[r].h, tbl[r].sel);
      chk($sformatf("row%0d.cycle", r), longint'(cyc),  longint'(tbl[r].ec));
      chk($sformatf("row%0d.tri", r),   longint'(tric), longint'(tbl[r].et));
      chk($sformatf("row%0d.samp", r),  longint'(smpc), longint'(tbl[r].es));
      chk($sformatf("row%0d.hit", r),   longint'(hitc), longint'(tbl[r].eh));
    end

    // Reset dropped between edges must clear outputs before any clock edge.
    for (int k = 0; k < 3; k++) step(1, 1, 1, k % 2);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("async.cycle", longint'(cyc),  0);
    chk("async.tri",   longint'(tric), 0);
    chk("async.samp",  longint'(smpc), 0);
    chk("async.hit",   longint'(hitc), 0);
    @(negedge clk);
    step(1, 0, 0, 0);
    step(1, 1, 0, 3);
    chk("restart.cycle", longint'(cyc),  2);
    chk("restart.tri",   longint'(tric), 1);
    chk("restart.samp",  longint'(smpc), 1);

    // Saturation of the 4-bit instance while the 32-bit one keeps counting.
    step(0, 0, 0, 0);
    for (int k = 0; k < 20; k++) step(1, 1, (k < 3), k % 2);
    chk("sat.cycle4", longint'(cyc4),  15);
    chk("sat.tri4",   longint'(tric4), 15);
    chk("sat.samp4",  longint'(smpc4), 15);
    chk("sat.hit4",   longint'(hitc4), 3);
    chk("sat.cycle",  longint'(cyc),   20);
    chk("sat.tri",    longint'(tric),  20);
    check_model("sat");

    // Random traffic against the reference model.
    step(0, 0, 0, 0);
    for (int k = 1; k <= 600; k++) begin
      int sel;
      bit r;
      sel = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : (k / 7) % 4;
      r   = ($urandom_range(0, 99) != 0);
      step(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sel);
      if (k % 25 == 0) check_model($sformatf("rand%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
